// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding, mode constants and sizing helper
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_DRAIN,
        ST_TAP_LOAD,
        ST_FIR_RUN,
        ST_FIR_DONE
    } state_t;

    localparam logic MODE_MM  = 1'b0;
    localparam logic MODE_FIR = 1'b1;

    // Bits needed to index 'value' entries; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// rtl/systolic_mac_pe.sv - DW-bit multiply-accumulate cell with synchronous clear
module systolic_mac_pe #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] prod;

    // Only the low DW bits of the product matter; results wrap modulo 2^DW.
    assign prod = a * b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/systolic_stream_acc.sv
// rtl/systolic_stream_acc.sv - streaming matrix-multiply / FIR systolic accelerator
module systolic_stream_acc
    import systolic_pkg::*;
#(
    parameter int DW   = 32,
    parameter int DIM  = 4,
    parameter int NTAP = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          keep_taps,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int NW = DIM * DIM;
    localparam int IW = clog2(NW);
    localparam int TW = clog2(NTAP);
    localparam int KW = clog2(DIM);
    localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);
    localparam logic [TW-1:0] TAP_LAST = TW'(NTAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(DIM - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] mm_idx;
    logic [TW-1:0] tap_idx;
    logic [KW-1:0] k_cnt;

    logic [DW-1:0] a_mat  [NW];
    logic [DW-1:0] b_mat  [NW];
    logic [DW-1:0] c_acc  [NW];
    logic [DW-1:0] a_col  [DIM];
    logic [DW-1:0] b_row  [DIM];
    logic [DW-1:0] taps   [NTAP];
    logic [DW-1:0] dline  [NTAP-1];
    logic [DW-1:0] x_next [NTAP];

    logic [DW-1:0] fir_sum;
    logic [DW-1:0] fir_data;
    logic [DW-1:0] drain_data;
    logic          fir_valid;
    logic          fir_last;
    logic          in_fire;
    logic          out_fire;
    logic          mm_start;
    logic          fir_start;
    logic          pe_en;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);
    assign mm_start  = (state == ST_IDLE) && start && (mode == MODE_MM);
    assign fir_start = (state == ST_IDLE) && start && (mode == MODE_FIR);
    assign pe_en     = (state == ST_COMPUTE);

    // MM results are read straight from the PE array; FIR uses its output register.
    assign out_valid = (state == ST_DRAIN) || fir_valid;
    assign out_data  = (state == ST_DRAIN) ? drain_data : fir_data;
    assign out_last  = (state == ST_DRAIN) ? (mm_idx == IDX_LAST) : fir_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_MM) begin
                        state_nxt = ST_LOAD_A;
                    end else if (keep_taps) begin
                        state_nxt = ST_FIR_RUN;
                    end else begin
                        state_nxt = ST_TAP_LOAD;
                    end
                end
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_fire && (mm_idx == IDX_LAST)) state_nxt = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_fire && (mm_idx == IDX_LAST)) state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (k_cnt == K_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_fire && (mm_idx == IDX_LAST)) state_nxt = ST_IDLE;
            end
            ST_TAP_LOAD: begin
                in_ready = 1'b1;
                if (in_fire && (tap_idx == TAP_LAST)) state_nxt = ST_FIR_RUN;
            end
            ST_FIR_RUN: begin
                in_ready = !fir_valid || out_ready;
                if (in_fire && in_last) state_nxt = ST_FIR_DONE;
            end
            ST_FIR_DONE: begin
                if (out_fire && fir_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Column k of A and row k of B broadcast to the whole PE array each compute cycle.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_col[i] = '0;
            b_row[i] = '0;
            for (int k = 0; k < DIM; k++) begin
                if (k_cnt == KW'(k)) begin
                    a_col[i] = a_mat[i*DIM + k];
                    b_row[i] = b_mat[k*DIM + i];
                end
            end
        end
    end

    always_comb begin
        drain_data = '0;
        for (int w = 0; w < NW; w++) begin
            if (mm_idx == IW'(w)) drain_data = c_acc[w];
        end
    end

    // y[n] uses the incoming sample as x[n], so the result is ready one cycle after accept.
    always_comb begin
        x_next[0] = in_data;
        for (int k = 1; k < NTAP; k++) begin
            x_next[k] = dline[k-1];
        end
        fir_sum = '0;
        for (int k = 0; k < NTAP; k++) begin
            fir_sum = fir_sum + DW'(taps[k] * x_next[k]);
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            systolic_mac_pe #(.DW(DW)) u_pe (
                .clk (clk),
                .rst (rst),
                .clr (mm_start),
                .en  (pe_en),
                .a   (a_col[gi]),
                .b   (b_row[gj]),
                .acc (c_acc[gi*DIM + gj])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_idx    <= '0;
            tap_idx   <= '0;
            k_cnt     <= '0;
            fir_valid <= 1'b0;
            fir_last  <= 1'b0;
            fir_data  <= '0;
            for (int w = 0; w < NW; w++) begin
                a_mat[w] <= '0;
                b_mat[w] <= '0;
            end
            for (int t = 0; t < NTAP; t++) begin
                taps[t] <= '0;
            end
            for (int t = 0; t < NTAP - 1; t++) begin
                dline[t] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    mm_idx  <= '0;
                    tap_idx <= '0;
                    k_cnt   <= '0;
                    if (fir_start) begin
                        for (int t = 0; t < NTAP - 1; t++) begin
                            dline[t] <= '0;
                        end
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (in_fire) begin
                        for (int w = 0; w < NW; w++) begin
                            if (mm_idx == IW'(w)) begin
                                if (state == ST_LOAD_A) a_mat[w] <= in_data;
                                else                    b_mat[w] <= in_data;
                            end
                        end
                        mm_idx <= (mm_idx == IDX_LAST) ? '0 : mm_idx + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
                end
                ST_DRAIN: begin
                    if (out_fire) mm_idx <= (mm_idx == IDX_LAST) ? '0 : mm_idx + 1'b1;
                end
                ST_TAP_LOAD: begin
                    if (in_fire) begin
                        for (int t = 0; t < NTAP; t++) begin
                            if (tap_idx == TW'(t)) taps[t] <= in_data;
                        end
                        tap_idx <= (tap_idx == TAP_LAST) ? '0 : tap_idx + 1'b1;
                    end
                end
                default: ;
            endcase

            if ((state == ST_FIR_RUN) && in_fire) begin
                dline[0] <= in_data;
                for (int t = 1; t < NTAP - 1; t++) begin
                    dline[t] <= dline[t-1];
                end
                fir_data  <= fir_sum;
                fir_valid <= 1'b1;
                fir_last  <= in_last;
            end else if (fir_valid && out_ready) begin
                fir_valid <= 1'b0;
                fir_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_stream_acc.sv
// tb/tb_systolic_stream_acc.sv - self-checking bench for systolic_stream_acc
module tb_systolic_stream_acc;

    typedef struct {
        logic [31:0] din;
        logic        din_last;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        keep_taps = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        toggle_rdy = 1'b0;
    out_t        exp_q[$];
    vec_t        fir_vec[15];
    logic [31:0] a_m[16];
    logic [31:0] b_m[16];

    logic        stall_prev = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;

    systolic_stream_acc #(.DW(32), .DIM(4), .NTAP(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .keep_taps (keep_taps),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = toggle_rdy ? !out_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, held_data);
                check("hold_last", {31'd0, out_last}, {31'd0, held_last});
            end
            if (out_valid && !out_ready) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    task automatic start_run(input logic m, input logic k);
        start = 1'b1;
        mode = m;
        keep_taps = k;
        @(posedge clk); #1;
        start = 1'b0;
        keep_taps = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic fir);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        if (fir) check("fir_latency", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_mm();
        logic [31:0] acc;
        int n;
        start_run(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc + a_m[i*4 + k] * b_m[k*4 + j];
                exp_q.push_back('{data: acc, last: (i == 3 && j == 3)});
            end
        end
        for (int w = 0; w < 16; w++) send(a_m[w], 1'b0, 1'b0);
        for (int w = 0; w < 16; w++) send(b_m[w], 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("compute_cycles", n, 32'd4);
        wait_idle();
    endtask

    task automatic load_identity();
        for (int w = 0; w < 16; w++) begin
            a_m[w] = (w % 5 == 0) ? 32'd1 : 32'd0;
            b_m[w] = w + 1;
        end
    endtask

    task automatic apply_vecs(input int first, input int last_i);
        for (int v = first; v <= last_i; v++) begin
            exp_q.push_back('{data: fir_vec[v].exp_data, last: fir_vec[v].exp_last});
            send(fir_vec[v].din, fir_vec[v].din_last, 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 11; i++) begin
            fir_vec[i] = '{din: (i == 0) ? 32'd1 : 32'd0, din_last: (i == 10),
                           exp_data: i + 1, exp_last: (i == 10)};
        end
        fir_vec[11] = '{din: 32'd2, din_last: 1'b0, exp_data: 32'd2, exp_last: 1'b0};
        fir_vec[12] = '{din: 32'd0, din_last: 1'b1, exp_data: 32'd4, exp_last: 1'b1};
        fir_vec[13] = '{din: 32'd7, din_last: 1'b0, exp_data: 32'd0, exp_last: 1'b0};
        fir_vec[14] = '{din: 32'd3, din_last: 1'b1, exp_data: 32'd0, exp_last: 1'b1};

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        load_identity();
        run_mm();

        for (int w = 0; w < 16; w++) begin
            a_m[w] = 32'h8000_0000;
            b_m[w] = 32'd2;
        end
        run_mm();
        for (int w = 0; w < 16; w++) begin
            a_m[w] = 32'd1;
            b_m[w] = 32'd3;
        end
        run_mm();

        start_run(1'b1, 1'b0);
        for (int t = 0; t < 11; t++) send(t + 1, 1'b0, 1'b0);
        apply_vecs(0, 10);
        wait_idle();

        start_run(1'b1, 1'b1);
        apply_vecs(11, 12);
        wait_idle();

        start_run(1'b1, 1'b0);
        for (int t = 0; t < 11; t++) send(32'd1, 1'b0, 1'b0);
        toggle_rdy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back('{data: 5 * (s + 1), last: (s == 2)});
            send(32'd5, (s == 2), 1'b1);
        end
        wait_idle();
        toggle_rdy = 1'b0;
        @(posedge clk); #1;

        pulse_reset();
        start_run(1'b1, 1'b1);
        apply_vecs(13, 14);
        wait_idle();

        load_identity();
        start_run(1'b0, 1'b0);
        for (int w = 0; w < 7; w++) send(a_m[w], 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        run_mm();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_stream_acc.md
Name: systolic_stream_acc

Overview:
Parametrised successor of the team's 4x4 MM / 11-tap FIR systolic accelerator. It works on a valid/ready input stream and a valid/ready output stream instead of a bare valid strobe. Matrix dimension, tap count and data width are parameters. A per-run control (start/mode/keep_taps) replaces the implicit counters. It sits between the user-project DMA/AXI-stream bridge and the Wishbone status registers.

Parameters:
DW, 32, data/accumulator width (two's complement, results wrap modulo 2^DW)
DIM, 4, square matrix dimension (legal 2..8)
NTAP, 11, FIR tap count (legal 2..32)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle run request; sampled only in IDLE
mode  in  1  0 = matrix multiply, 1 = FIR; sampled with start
keep_taps  in  1  FIR only: 1 = reuse stored taps and skip tap load; sampled with start
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  DW  input word
in_last  in  1  FIR: marks the final sample; ignored in MM
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  DW  output word
out_last  out  1  final output word of the run
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. Reset forces state to IDLE and zeroes all outputs, the accumulators, the FIR delay line and the tap store. A reset mid-run aborts the run with no partial output.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, TAP_LOAD, FIR_RUN, FIR_DONE.
- IDLE: in_ready=0 and input is ignored.
  - start with mode=0 -> LOAD_A.
  - start with mode=1 and keep_taps=0 -> TAP_LOAD.
  - start with mode=1 and keep_taps=1 -> FIR_RUN.
  - start while busy is ignored.
- LOAD_A / LOAD_B: in_ready=1. Each accepts DIM*DIM words in row-major order: A[0][0], A[0][1], ... Accumulators are cleared on entry to LOAD_A. After the last accepted word of A -> LOAD_B; after the last word of B -> COMPUTE.
- COMPUTE: in_ready=0. Takes exactly DIM cycles; in cycle k every PE does C[i][j] += A[i][k]*B[k][j], keeping the low DW bits of the product and the sum. Then -> DRAIN.
- DRAIN: emits C row-major, DIM*DIM words.
  - out_valid=1 from the first DRAIN cycle.
  - The index advances only on out_valid && out_ready.
  - out_data and out_last stay stable while stalled.
  - out_last is high on the final word; that handshake -> IDLE.
- TAP_LOAD: in_ready=1. Accepts NTAP words into h[0]..h[NTAP-1], first word is h[0]. Clears the delay line. After the last tap -> FIR_RUN.
- FIR_RUN: in_ready = !out_valid || out_ready (single output register).
  - An accepted sample x shifts into the delay line.
  - The next cycle out_valid=1 with y = sum over k of h[k]*x[n-k], wrapped to DW bits. Samples before the run start count as 0.
  - Latency is 1 cycle from accept to out_valid; full throughput is 1 word/cycle when out_ready stays high.
  - Accepting a sample with in_last=1 -> FIR_DONE; that sample's output carries out_last=1.
- FIR_DONE: in_ready=0. Holds until the out_last handshake -> IDLE.
- keep_taps=1 with no tap set loaded since reset uses all-zero taps, so outputs are 0.
- Simultaneous events: with out_valid && out_ready && in_valid in the same cycle, the register reloads with the new result with no bubble.
- busy drops the cycle after the final output handshake.

Decomposition:
- Package systolic_pkg: state enum, MODE_MM=0 / MODE_FIR=1 constants, function clog2 for counter widths.
- One sub-module, systolic_mac_pe: DW-bit multiply-accumulate with a synchronous clear. It is instantiated DIM*DIM times for MM. The FIR path uses a combinational adder tree over NTAP products in the top level.
- Counters: word index sized clog2(DIM*DIM) and clog2(NTAP); k counter sized clog2(DIM).

Test Plan:
- MM identity: A=I4, B=1..16 row-major, out_ready=1 -> out 1..16 in order, out_last on the 16th word; COMPUTE lasts 4 cycles; busy low afterwards.
- MM wrap: A all 0x80000000, B all 2 -> all 16 outputs 0x00000000. Then A all 1, B all 3 -> all outputs 12.
- FIR impulse: taps 1..11, samples 1 then ten 0s, last on the 11th -> outputs 1,2,...,11, each 1 cycle after accept, out_last on 11.
- Backpressure: FIR taps all 1, samples 5,5,5 with out_ready toggling 0/1 -> in_ready low while the output is stalled; outputs 5,10,15 held stable and none lost or duplicated.
- keep_taps: after the impulse run, start mode=1 keep_taps=1, samples 2,0 -> outputs 2,4 with no tap words consumed. After reset with keep_taps=1 -> outputs 0.
- Reset mid-run: assert rst after 7 words of LOAD_A -> busy=0, in_ready=0, out_valid=0 immediately. A fresh identity MM run then produces correct results.
